router_param: RTL and testbench

- Parametrised packet router. Takes one byte-serial input stream and splits it into NUM_CH output channels, each with its own FIFO.
- Replaces the fixed 3-channel, depth-4 router. New features: backpressure (busy stall), dropping of packets with an invalid destination, and a per-channel read-timeout soft reset.
- Sits between the pin-mapped input bus and the per-channel readers in the top wrapper.

---
 rtl/router_param.sv | 191 +++++++++++++++++++
 tb/tb_router_param.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_param.sv
// Byte-serial packet router: one input stream split into NUM_CH first-word-fall-through FIFOs,
// with input backpressure, invalid-destination dropping and a per-channel read-timeout flush.
module router_param #(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     packet_valid,
    input  logic [DATA_W-1:0]        datain,
    input  logic [NUM_CH-1:0]        read_enb,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        vldout,
    output logic                     busy,
    output logic                     err,
    output logic                     drop,
    output logic [NUM_CH-1:0]        soft_rst
);

    localparam int ADDR_W = 2;
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DROP   = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] dest_q;
    logic [LEN_W-1:0]  rem;
    logic [DATA_W-1:0] par;
    logic [DATA_W-1:0] recv;

    logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [CNT_W-1:0]  count  [NUM_CH];
    logic [TMR_W-1:0]  tmr    [NUM_CH];

    logic [ADDR_W-1:0] dest_in;
    logic [LEN_W-1:0]  len_in;
    logic              hdr_ok;
    logic [ADDR_W-1:0] tgt;
    logic              tgt_full;
    logic              wr_path;
    logic              accept;
    logic              write;
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] tmo;

    assign dest_in = datain[ADDR_W-1:0];
    assign len_in  = datain[DATA_W-1:ADDR_W];
    assign hdr_ok  = ({1'b0, dest_in} < NUM_CH_W);
    assign tgt     = (state == S_IDLE) ? dest_in : dest_q;

    // Stalls only depend on registered state and counts, so a full FIFO stalls even if it is being popped.
    assign wr_path = ((state == S_IDLE) && packet_valid && hdr_ok) ||
                     (state == S_LOAD) || (state == S_PARITY);
    assign busy    = (wr_path && tgt_full) || (state == S_CHECK);
    assign accept  = packet_valid && !busy;
    assign write   = accept && wr_path;
    assign vldout  = vld;

    // NOTE: every variable written here gets a default first, otherwise synthesis infers latches.
    always_comb begin
        tgt_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tgt == ADDR_W'(i)) tgt_full = (count[i] == CNT_W'(DEPTH));
        end
    end

    always_comb begin
        vld      = '0;
        pop      = '0;
        tmo      = '0;
        push     = '0;
        data_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            vld[i]  = (count[i] != '0);
            pop[i]  = read_enb[i] && vld[i];
            tmo[i]  = vld[i] && !read_enb[i] && (tmr[i] == TMR_W'(TIMEOUT - 1));
            push[i] = write && (tgt == ADDR_W'(i)) && !tmo[i];
            if (vld[i]) data_out[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]];
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count, so stale contents are never visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= datain;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            soft_rst <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                tmr[i]    <= '0;
            end
        end else begin
            soft_rst <= tmo;
            for (int i = 0; i < NUM_CH; i++) begin
                if (tmo[i]) begin
                    // Flush wins over a coinciding push; the byte is lost.
                    count[i]  <= '0;
                    rd_ptr[i] <= wr_ptr[i];
                    tmr[i]    <= '0;
                end else begin
                    if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                    if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                    case ({push[i], pop[i]})
                        2'b10:   count[i] <= count[i] + CNT_W'(1);
                        2'b01:   count[i] <= count[i] - CNT_W'(1);
                        default: count[i] <= count[i];
                    endcase
                    if (pop[i] || !vld[i]) tmr[i] <= '0;
                    else                   tmr[i] <= tmr[i] + TMR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            dest_q <= '0;
            rem    <= '0;
            par    <= '0;
            recv   <= '0;
            err    <= 1'b0;
            drop   <= 1'b0;
        end else begin
            err  <= 1'b0;
            drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (packet_valid && !hdr_ok) begin
                        drop  <= 1'b1;
                        state <= S_DROP;
                    end else if (accept) begin
                        dest_q <= dest_in;
                        rem    <= len_in;
                        par    <= datain;
                        state  <= (len_in != '0) ? S_LOAD : S_PARITY;
                    end
                end
                S_LOAD: begin
                    if (!packet_valid) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else if (accept) begin
                        par <= par ^ datain;
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (!packet_valid) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else if (accept) begin
                        recv  <= datain;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    err   <= (par != recv);
                    state <= S_IDLE;
                end
                S_DROP: begin
                    if (!packet_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_param.sv
// Directed and randomized bench for router_param; expected FIFO contents come from per-channel
// byte lists and the packet rules (XOR parity, dest/len header fields, timeout in cycles).
module tb_router_param;

    localparam int NUM_CH  = 3;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic                     clk = 1'b0;
    logic                     resetn = 1'b0;
    logic                     packet_valid = 1'b0;
    logic [DATA_W-1:0]        datain = '0;
    logic [NUM_CH-1:0]        read_enb = '0;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic [NUM_CH-1:0]        vldout;
    logic                     busy;
    logic                     err;
    logic                     drop;
    logic [NUM_CH-1:0]        soft_rst;

    router_param #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .packet_valid(packet_valid),
        .datain      (datain),
        .read_enb    (read_enb),
        .data_out    (data_out),
        .vldout      (vldout),
        .busy        (busy),
        .err         (err),
        .drop        (drop),
        .soft_rst    (soft_rst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference: what each channel FIFO should hold, oldest first.
    logic [7:0] mdl [NUM_CH][64];
    int         mdl_wr [NUM_CH];
    int         mdl_rd [NUM_CH];
    logic [7:0] pkt [64];
    int         pkt_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_push(input int ch, input logic [7:0] b);
        mdl[ch][mdl_wr[ch] % 64] = b;
        mdl_wr[ch]++;
    endtask

    task automatic mdl_clear(input int ch);
        mdl_rd[ch] = mdl_wr[ch];
    endtask

    function automatic logic [NUM_CH-1:0] mdl_vld();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = (mdl_wr[c] != mdl_rd[c]);
        return v;
    endfunction

    // Appends XOR parity over header and payload; pkt[0] and the payload must already be filled.
    task automatic finish_pkt(input logic corrupt);
        int len;
        logic [7:0] p;
        len = int'(pkt[0][7:2]);
        p = '0;
        for (int i = 0; i <= len; i++) p ^= pkt[i];
        if (corrupt) p ^= 8'($urandom_range(1, 255));
        pkt[len+1] = p;
        pkt_n = len + 2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        packet_valid = 1'b1;
        datain = b;
        @(negedge clk);
        while (busy === 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) check("busy_bound", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one(input int ch);
        check("pop_vld", 32'(vldout[ch]), 32'(1));
        check("pop_head", 32'(data_out[ch*8 +: 8]), 32'(mdl[ch][mdl_rd[ch] % 64]));
        read_enb[ch] = 1'b1;
        @(posedge clk);
        #1;
        read_enb[ch] = 1'b0;
        mdl_rd[ch]++;
    endtask

    task automatic drain(input int ch);
        int guard;
        guard = 0;
        while (mdl_rd[ch] != mdl_wr[ch] && guard < 64) begin
            pop_one(ch);
            guard++;
        end
        check("drain_vld", 32'(vldout[ch]), 32'(0));
        check("drain_data", 32'(data_out[ch*8 +: 8]), 32'(0));
    endtask

    task automatic send_packet(input logic exp_corrupt);
        int   ch;
        logic valid;
        ch = int'(pkt[0][1:0]);
        valid = (ch < NUM_CH);
        send_byte(pkt[0]);
        check("drop_hdr", 32'(drop), 32'(!valid));
        if (valid) mdl_push(ch, pkt[0]);
        for (int i = 1; i < pkt_n; i++) begin
            send_byte(pkt[i]);
            if (valid) mdl_push(ch, pkt[i]);
            if (i == 1) check("drop_once", 32'(drop), 32'(0));
        end
        if (valid) begin
            check("busy_in_check", 32'(busy), 32'(1));
            check("err_in_check", 32'(err), 32'(0));
        end
        packet_valid = 1'b0;
        @(posedge clk);
        #1;
        if (valid) begin
            check("err_pulse", 32'(err), 32'(exp_corrupt));
            check("busy_after", 32'(busy), 32'(0));
        end else begin
            check("drop_no_write", 32'(vldout), 32'(mdl_vld()));
        end
        @(posedge clk);
        #1;
        check("err_clear", 32'(err), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vldout"}, 32'(vldout), 32'(0));
        check({tag, "_data_out"}, 32'(data_out), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_drop"}, 32'(drop), 32'(0));
        check({tag, "_soft_rst"}, 32'(soft_rst), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int pc;
        int hit;
        int early;
        int dest;
        int len;
        logic corrupt;

        for (int c = 0; c < NUM_CH; c++) begin
            mdl_wr[c] = 0;
            mdl_rd[c] = 0;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Good packet to channel 1.
        pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33;
        finish_pkt(1'b0);
        send_packet(1'b0);
        check("good_vldout", 32'(vldout), 32'(3'b010));
        drain(1);

        // Same packet with a wrong parity byte.
        pkt[4] = 8'hFF;
        send_packet(1'b1);
        check("badpar_vldout", 32'(vldout), 32'(3'b010));
        drain(1);

        // Invalid destination, then a normal packet to channel 0.
        pkt[0] = 8'h07; pkt[1] = 8'h5A; pkt[2] = 8'hA5; pkt[3] = 8'h3C;
        pkt_n = 4;
        send_packet(1'b0);
        check("drop_vldout", 32'(vldout), 32'(0));
        pkt[0] = 8'h04; pkt[1] = 8'hAA;
        finish_pkt(1'b0);
        send_packet(1'b0);
        drain(0);

        // Backpressure: 22-byte packet into a 16-deep FIFO.
        pkt[0] = 8'h50;
        for (int i = 1; i <= 20; i++) pkt[i] = 8'($urandom);
        finish_pkt(1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            packet_valid = 1'b1;
            datain = pkt[k];
            @(negedge clk);
            check("bp_free", 32'(busy), 32'(0));
            @(posedge clk);
            #1;
            mdl_push(0, pkt[k]);
        end
        datain = pkt[DEPTH];
        @(negedge clk);
        check("bp_full", 32'(busy), 32'(1));
        repeat (2) begin
            @(negedge clk);
            check("bp_hold", 32'(busy), 32'(1));
        end
        @(posedge clk);
        #1;
        check("bp_head", 32'(data_out[7:0]), 32'(mdl[0][mdl_rd[0] % 64]));
        read_enb[0] = 1'b1;
        @(negedge clk);
        check("bp_no_bypass", 32'(busy), 32'(1));
        @(posedge clk);
        #1;
        read_enb[0] = 1'b0;
        mdl_rd[0]++;
        @(negedge clk);
        check("bp_release", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        mdl_push(0, pkt[DEPTH]);
        for (int k = DEPTH + 1; k < pkt_n; k++) begin
            datain = pkt[k];
            pop_one(0);
            send_byte(pkt[k]);
            mdl_push(0, pkt[k]);
        end
        check("bp_check_busy", 32'(busy), 32'(1));
        packet_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_err", 32'(err), 32'(0));
        drain(0);

        // Timeout flush of two unread bytes in channel 2.
        pkt[0] = 8'h02;
        finish_pkt(1'b0);
        send_byte(pkt[0]);
        mdl_push(2, pkt[0]);
        c0 = cyc;
        send_byte(pkt[1]);
        mdl_push(2, pkt[1]);
        packet_valid = 1'b0;
        hit = -1;
        for (int k = 0; k < 40 && hit < 0; k++) begin
            @(posedge clk);
            #1;
            if (soft_rst[2]) hit = cyc;
        end
        check("tmo_latency", 32'(hit - c0), 32'(TIMEOUT));
        check("tmo_vld", 32'(vldout[2]), 32'(0));
        check("tmo_data", 32'(data_out[23:16]), 32'(0));
        mdl_clear(2);
        @(posedge clk);
        #1;
        check("tmo_pulse", 32'(soft_rst), 32'(0));

        // A pop one cycle before expiry restarts the count.
        send_byte(pkt[0]);
        mdl_push(2, pkt[0]);
        c0 = cyc;
        send_byte(pkt[1]);
        mdl_push(2, pkt[1]);
        packet_valid = 1'b0;
        early = 0;
        for (int k = 0; k < 40 && cyc < c0 + TIMEOUT - 2; k++) begin
            @(posedge clk);
            #1;
            if (soft_rst[2]) early = 1;
        end
        check("tmo_early", 32'(early), 32'(0));
        pop_one(2);
        pc = cyc;
        hit = -1;
        for (int k = 0; k < 40 && hit < 0; k++) begin
            @(posedge clk);
            #1;
            if (soft_rst[2]) hit = cyc;
        end
        check("tmo_restart", 32'(hit - pc), 32'(TIMEOUT));
        check("tmo_restart_vld", 32'(vldout[2]), 32'(0));
        mdl_clear(2);
        @(posedge clk);
        #1;

        // Early end after 2 of 5 payload bytes, then a normal packet proves IDLE.
        pkt[0] = 8'h15; pkt[1] = 8'h81; pkt[2] = 8'h42;
        for (int i = 0; i < 3; i++) begin
            send_byte(pkt[i]);
            mdl_push(1, pkt[i]);
        end
        packet_valid = 1'b0;
        @(posedge clk);
        #1;
        check("early_err", 32'(err), 32'(1));
        check("early_vld", 32'(vldout), 32'(3'b010));
        @(posedge clk);
        #1;
        check("early_err_clear", 32'(err), 32'(0));
        pkt[0] = 8'h00;
        finish_pkt(1'b0);
        send_packet(1'b0);
        drain(1);
        drain(0);

        // Reset mid-packet clears outputs before the next clock edge.
        send_byte(8'h0D);
        send_byte(8'h11);
        check("mid_vld", 32'(vldout), 32'(3'b010));
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        packet_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) mdl_clear(c);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Random packets, drained after each one.
        for (int n = 0; n < 40; n++) begin
            dest = int'($urandom_range(0, 3));
            len = int'($urandom_range(0, 8));
            corrupt = ($urandom_range(0, 3) == 0);
            pkt[0] = {6'(len), 2'(dest)};
            for (int i = 1; i <= len; i++) pkt[i] = 8'($urandom);
            finish_pkt(corrupt);
            send_packet(corrupt);
            if (dest < NUM_CH) drain(dest);
        end
        check("final_vld", 32'(vldout), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
